// File: rtl/prl_tx_message_path.sv
// prl_tx_message_path: assembles PD message header, extended header and data objects
// and streams them LSB-byte-first to the PHY under a byte-pull handshake.
module prl_tx_message_path #(
    parameter int MAX_DATA_OBJ = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prl_tx_message_req,
    input  logic [2:0]  prl_tx_sop_type,
    input  logic [1:0]  prl_tx_message_type,
    input  logic [4:0]  prl_tx_header_type,
    input  logic [2:0]  prl_tx_message_id,
    input  logic [2:0]  prl_tx_num_data_obj,
    input  logic        prl_tx_port_data_role,
    input  logic [1:0]  prl_tx_spec_rev,
    input  logic        prl_tx_port_power_role,
    input  logic [8:0]  prl_tx_ex_data_size,
    input  logic [31:0] prl_tx_data_obj,
    output logic [2:0]  prl_tx_data_obj_idx,
    output logic        prl_tx_busy,
    output logic        prl_tx_message_done,
    output logic [1:0]  prl_tx_message_result,
    output logic        prl2phy_tx_packet_en,
    output logic [2:0]  prl2phy_tx_packet_type,
    output logic [7:0]  prl2phy_tx_payload,
    output logic        prl2phy_tx_payload_last,
    input  logic        phy2prl_tx_payload_req,
    input  logic        phy2prl_tx_packet_done,
    input  logic [1:0]  phy2prl_tx_packet_result
);
    typedef enum logic [2:0] {IDLE, HEADER, EXT_HEADER, DATA, WAIT_DONE} state_t;
    state_t      state_q;
    logic [7:0]  hdr_hi_q, payload_q;
    logic [15:0] ext_hdr_q;
    logic [2:0]  ndo_q, cnt_q, idx_q, type_q;
    logic        ext_q, busy_q, done_q, pkt_en_q, last_q;
    logic [1:0]  result_q;
    logic        is_ext, is_ctrl, is_hard, last_obj, adv;
    logic [2:0]  ndo_d;
    logic [15:0] hdr_d, ext_hdr_d;
    logic [1:0]  byte_sel;
    logic [7:0]  byte_d;
    assign is_ext    = prl_tx_message_type == 2'd2;
    assign is_ctrl   = prl_tx_message_type == 2'd0 || prl_tx_message_type == 2'd3;
    assign is_hard   = prl_tx_sop_type >= 3'd3;
    assign ndo_d     = is_ctrl ? 3'd0 :
                       int'(prl_tx_num_data_obj) > MAX_DATA_OBJ ? 3'(MAX_DATA_OBJ) : prl_tx_num_data_obj;
    assign hdr_d     = {is_ext, ndo_d, prl_tx_message_id, prl_tx_port_power_role,
                        prl_tx_spec_rev, prl_tx_port_data_role, prl_tx_header_type};
    assign ext_hdr_d = {1'b1, 4'h0, 1'b0, 1'b0, prl_tx_ex_data_size};
    assign last_obj  = idx_q == ndo_q - 3'd1;
    // the index moves in the consume cycle so the next object's byte 0 is fetched in time
    assign adv       = state_q == DATA && cnt_q == 3'd3 && phy2prl_tx_payload_req &&
                       !phy2prl_tx_packet_done && !last_obj;
    assign byte_sel  = cnt_q[1:0] + 2'd1;
    assign byte_d    = prl_tx_data_obj[{byte_sel, 3'b000} +: 8];
    assign prl_tx_data_obj_idx     = idx_q + {2'b00, adv};
    assign prl_tx_busy             = busy_q;
    assign prl_tx_message_done     = done_q;
    assign prl_tx_message_result   = result_q;
    assign prl2phy_tx_packet_en    = pkt_en_q;
    assign prl2phy_tx_packet_type  = type_q;
    assign prl2phy_tx_payload      = payload_q;
    assign prl2phy_tx_payload_last = last_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_hi_q  <= '0;
            ext_hdr_q <= '0;
            ndo_q     <= '0;
            ext_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            type_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pkt_en_q  <= 1'b0;
            last_q    <= 1'b0;
            result_q  <= '0;
            payload_q <= '0;
        end else begin
            pkt_en_q <= 1'b0;
            done_q   <= 1'b0;
            if (state_q == IDLE) begin
                if (prl_tx_message_req && !done_q) begin
                    hdr_hi_q  <= hdr_d[15:8];
                    ext_hdr_q <= ext_hdr_d;
                    ndo_q     <= ndo_d;
                    ext_q     <= is_ext;
                    type_q    <= prl_tx_sop_type;
                    busy_q    <= 1'b1;
                    pkt_en_q  <= 1'b1;
                    cnt_q     <= '0;
                    idx_q     <= '0;
                    last_q    <= 1'b0;
                    payload_q <= is_hard ? 8'h00 : hdr_d[7:0];
                    state_q   <= is_hard ? WAIT_DONE : HEADER;
                end
            end else if (phy2prl_tx_packet_done) begin
                // an early finish with an ok status still means the payload was cut short
                result_q  <= (state_q != WAIT_DONE && phy2prl_tx_packet_result == 2'd0) ?
                             2'h3 : phy2prl_tx_packet_result;
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                cnt_q     <= '0;
                last_q    <= 1'b0;
                payload_q <= '0;
            end else if (phy2prl_tx_payload_req && state_q != WAIT_DONE) begin
                case (state_q)
                    HEADER: begin
                        if (cnt_q == 3'd0) begin
                            payload_q <= hdr_hi_q;
                            cnt_q     <= 3'd1;
                            last_q    <= !ext_q && ndo_q == 3'd0;
                        end else begin
                            cnt_q     <= '0;
                            last_q    <= 1'b0;
                            state_q   <= ext_q ? EXT_HEADER : ndo_q != 3'd0 ? DATA : WAIT_DONE;
                            payload_q <= ext_q ? ext_hdr_q[7:0] :
                                         ndo_q != 3'd0 ? prl_tx_data_obj[7:0] : 8'h00;
                        end
                    end
                    EXT_HEADER: begin
                        if (cnt_q == 3'd0) begin
                            payload_q <= ext_hdr_q[15:8];
                            cnt_q     <= 3'd1;
                            last_q    <= ndo_q == 3'd0;
                        end else begin
                            cnt_q     <= '0;
                            last_q    <= 1'b0;
                            state_q   <= ndo_q != 3'd0 ? DATA : WAIT_DONE;
                            payload_q <= ndo_q != 3'd0 ? prl_tx_data_obj[7:0] : 8'h00;
                        end
                    end
                    default: begin
                        if (cnt_q != 3'd3) begin
                            payload_q <= byte_d;
                            cnt_q     <= cnt_q + 3'd1;
                            last_q    <= cnt_q == 3'd2 && last_obj;
                        end else begin
                            cnt_q     <= '0;
                            last_q    <= 1'b0;
                            state_q   <= last_obj ? WAIT_DONE : DATA;
                            payload_q <= last_obj ? 8'h00 : prl_tx_data_obj[7:0];
                            idx_q     <= last_obj ? idx_q : idx_q + 3'd1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prl_tx_message_path.sv
// tb_prl_tx_message_path: checks the TX message builder against a byte-list model of the message.
module tb_prl_tx_message_path;
    logic        clk = 1'b0;
    logic        rst;
    logic        prl_tx_message_req;
    logic [2:0]  prl_tx_sop_type;
    logic [1:0]  prl_tx_message_type;
    logic [4:0]  prl_tx_header_type;
    logic [2:0]  prl_tx_message_id;
    logic [2:0]  prl_tx_num_data_obj;
    logic        prl_tx_port_data_role;
    logic [1:0]  prl_tx_spec_rev;
    logic        prl_tx_port_power_role;
    logic [8:0]  prl_tx_ex_data_size;
    logic [31:0] prl_tx_data_obj;
    logic [2:0]  prl_tx_data_obj_idx;
    logic        prl_tx_busy;
    logic        prl_tx_message_done;
    logic [1:0]  prl_tx_message_result;
    logic        prl2phy_tx_packet_en;
    logic [2:0]  prl2phy_tx_packet_type;
    logic [7:0]  prl2phy_tx_payload;
    logic        prl2phy_tx_payload_last;
    logic        phy2prl_tx_payload_req;
    logic        phy2prl_tx_packet_done;
    logic [1:0]  phy2prl_tx_packet_result;
    logic [31:0] objs [0:7];
    logic [7:0]  exp_b [$];
    int          exp_i [$];
    int          errors = 0;
    int          checks = 0;
    always #5 clk = ~clk;
    assign prl_tx_data_obj = objs[prl_tx_data_obj_idx];
    prl_tx_message_path dut (
        .clk(clk), .rst(rst),
        .prl_tx_message_req(prl_tx_message_req), .prl_tx_sop_type(prl_tx_sop_type),
        .prl_tx_message_type(prl_tx_message_type), .prl_tx_header_type(prl_tx_header_type),
        .prl_tx_message_id(prl_tx_message_id), .prl_tx_num_data_obj(prl_tx_num_data_obj),
        .prl_tx_port_data_role(prl_tx_port_data_role), .prl_tx_spec_rev(prl_tx_spec_rev),
        .prl_tx_port_power_role(prl_tx_port_power_role), .prl_tx_ex_data_size(prl_tx_ex_data_size),
        .prl_tx_data_obj(prl_tx_data_obj), .prl_tx_data_obj_idx(prl_tx_data_obj_idx),
        .prl_tx_busy(prl_tx_busy), .prl_tx_message_done(prl_tx_message_done),
        .prl_tx_message_result(prl_tx_message_result), .prl2phy_tx_packet_en(prl2phy_tx_packet_en),
        .prl2phy_tx_packet_type(prl2phy_tx_packet_type), .prl2phy_tx_payload(prl2phy_tx_payload),
        .prl2phy_tx_payload_last(prl2phy_tx_payload_last), .phy2prl_tx_payload_req(phy2prl_tx_payload_req),
        .phy2prl_tx_packet_done(phy2prl_tx_packet_done), .phy2prl_tx_packet_result(phy2prl_tx_packet_result)
    );
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic set_req(input logic [2:0] sop, input logic [1:0] mt, input logic [4:0] ht,
                           input logic [2:0] id, input logic [2:0] ndo, input logic dr,
                           input logic [1:0] sr, input logic pr, input logic [8:0] exs);
        prl_tx_sop_type = sop; prl_tx_message_type = mt; prl_tx_header_type = ht;
        prl_tx_message_id = id; prl_tx_num_data_obj = ndo; prl_tx_port_data_role = dr;
        prl_tx_spec_rev = sr; prl_tx_port_power_role = pr; prl_tx_ex_data_size = exs;
    endtask
    // Expected byte stream and object index per byte, from the message field layout.
    task automatic model_build();
        int ext, ndo, hdr, eh;
        exp_b.delete();
        exp_i.delete();
        if (prl_tx_sop_type >= 3) return;
        ext = (prl_tx_message_type == 2) ? 1 : 0;
        ndo = (prl_tx_message_type == 1 || ext == 1) ? int'(prl_tx_num_data_obj) : 0;
        if (ndo > 7) ndo = 7;
        hdr = int'(prl_tx_header_type) + 32 * int'(prl_tx_port_data_role) + 64 * int'(prl_tx_spec_rev)
            + 256 * int'(prl_tx_port_power_role) + 512 * int'(prl_tx_message_id) + 4096 * ndo + 32768 * ext;
        exp_b.push_back(8'(hdr % 256)); exp_i.push_back(0);
        exp_b.push_back(8'(hdr / 256)); exp_i.push_back(0);
        if (ext == 1) begin
            eh = 32768 + int'(prl_tx_ex_data_size);
            exp_b.push_back(8'(eh % 256)); exp_i.push_back(0);
            exp_b.push_back(8'(eh / 256)); exp_i.push_back(0);
        end
        for (int o = 0; o < ndo; o++)
            for (int b = 0; b < 4; b++) begin
                exp_b.push_back(8'((objs[o] >> (8 * b)) & 32'hFF));
                exp_i.push_back(o);
            end
    endtask
    task automatic send(input int stall_max, input int stall_at, input int abort_at,
                        input logic [1:0] phy_res, input bit busy_req);
        int n;
        bit aborted;
        logic [7:0] held;
        logic [1:0] want_res;
        model_build();
        n = exp_b.size();
        aborted = 0;
        @(negedge clk); prl_tx_message_req = 1'b1;
        @(posedge clk); #1 prl_tx_message_req = 1'b0;
        @(negedge clk);
        checks += 3;
        if (prl2phy_tx_packet_en !== 1'b1) begin errors++; $display("FAIL packet_en: got %b want 1", prl2phy_tx_packet_en); end
        if (prl_tx_busy !== 1'b1) begin errors++; $display("FAIL busy_on_accept: got %b want 1", prl_tx_busy); end
        if (prl2phy_tx_packet_type !== prl_tx_sop_type) begin errors++; $display("FAIL packet_type: got %0d want %0d", prl2phy_tx_packet_type, prl_tx_sop_type); end
        held = prl2phy_tx_payload;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin aborted = 1; break; end
            repeat ((k == stall_at) ? 5 : $urandom_range(0, stall_max)) begin
                @(posedge clk); #1;
                @(negedge clk);
                checks++;
                if (prl2phy_tx_payload !== exp_b[k]) begin errors++; $display("FAIL byte_hold[%0d]: got %h want %h", k, prl2phy_tx_payload, exp_b[k]); end
            end
            checks += 3;
            if (prl2phy_tx_payload !== exp_b[k]) begin errors++; $display("FAIL byte[%0d]: got %h want %h", k, prl2phy_tx_payload, exp_b[k]); end
            if (prl2phy_tx_payload_last !== (k == n - 1)) begin errors++; $display("FAIL last[%0d]: got %b want %b", k, prl2phy_tx_payload_last, k == n - 1); end
            if (prl_tx_data_obj_idx !== 3'(exp_i[k])) begin errors++; $display("FAIL obj_idx[%0d]: got %0d want %0d", k, prl_tx_data_obj_idx, exp_i[k]); end
            phy2prl_tx_payload_req = 1'b1;
            prl_tx_message_req = busy_req && k == 1;
            @(posedge clk); #1 phy2prl_tx_payload_req = 1'b0; prl_tx_message_req = 1'b0;
            @(negedge clk);
            checks++;
            if (prl2phy_tx_packet_en !== 1'b0) begin errors++; $display("FAIL no_restart[%0d]: got %b want 0", k, prl2phy_tx_packet_en); end
        end
        if (!aborted) begin
            repeat (2) begin
                phy2prl_tx_payload_req = 1'b1;
                @(posedge clk); #1 phy2prl_tx_payload_req = 1'b0;
                @(negedge clk);
                checks += 3;
                if (prl2phy_tx_payload_last !== 1'b0) begin errors++; $display("FAIL wait_last: got %b want 0", prl2phy_tx_payload_last); end
                if (prl_tx_busy !== 1'b1 || prl_tx_message_done !== 1'b0) begin errors++; $display("FAIL wait_busy: got busy=%b done=%b want 1/0", prl_tx_busy, prl_tx_message_done); end
                if (n == 0 && prl2phy_tx_payload !== held) begin errors++; $display("FAIL no_payload: got %h want %h", prl2phy_tx_payload, held); end
                else if (n != 0 && prl2phy_tx_payload === 8'hxx) begin errors++; $display("FAIL wait_payload: got %h want known", prl2phy_tx_payload); end
            end
        end
        want_res = (aborted && phy_res == 2'd0) ? 2'h3 : phy_res;
        phy2prl_tx_packet_done = 1'b1;
        phy2prl_tx_packet_result = phy_res;
        phy2prl_tx_payload_req = aborted;
        @(posedge clk); #1 phy2prl_tx_packet_done = 1'b0; phy2prl_tx_payload_req = 1'b0;
        @(negedge clk);
        checks += 3;
        if (prl_tx_message_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", prl_tx_message_done); end
        if (prl_tx_message_result !== want_res) begin errors++; $display("FAIL result: got %0d want %0d", prl_tx_message_result, want_res); end
        if (prl_tx_busy !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b want 0", prl_tx_busy); end
        prl_tx_message_req = 1'b1;
        @(posedge clk); #1 prl_tx_message_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (prl_tx_message_done !== 1'b0) begin errors++; $display("FAIL done_single: got %b want 0", prl_tx_message_done); end
        if (prl2phy_tx_packet_en !== 1'b0 || prl_tx_busy !== 1'b0) begin errors++; $display("FAIL req_at_done: got en=%b busy=%b want 0/0", prl2phy_tx_packet_en, prl_tx_busy); end
    endtask
    task automatic check_all_zero(input string tag);
        checks++;
        if ({prl_tx_data_obj_idx, prl_tx_busy, prl_tx_message_done, prl_tx_message_result, prl2phy_tx_packet_en,
             prl2phy_tx_packet_type, prl2phy_tx_payload, prl2phy_tx_payload_last} !== 22'd0) begin
            errors++;
            $display("FAIL %s: got idx=%0d busy=%b done=%b res=%0d en=%b type=%0d pay=%h last=%b want all 0", tag,
                     prl_tx_data_obj_idx, prl_tx_busy, prl_tx_message_done, prl_tx_message_result,
                     prl2phy_tx_packet_en, prl2phy_tx_packet_type, prl2phy_tx_payload, prl2phy_tx_payload_last);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1 rst = 1'b0;
    endtask
    task automatic test_goodcrc();
        set_req(3'd0, 2'd0, 5'h01, 3'd3, 3'd5, 1'b1, 2'd2, 1'b1, 9'h0);
        send(0, -1, -1, 2'd0, 1'b0);
    endtask
    task automatic test_data_msg();
        objs[0] = 32'h1304B12C;
        set_req(3'd0, 2'd1, 5'h02, 3'd0, 3'd1, 1'b0, 2'd2, 1'b0, 9'h0);
        send(1, -1, -1, 2'd0, 1'b1);
    endtask
    task automatic test_extended();
        objs[0] = 32'hA1B2C3D4; objs[1] = 32'h55667788;
        set_req(3'd1, 2'd2, 5'h0F, 3'd6, 3'd2, 1'b1, 2'd2, 1'b0, 9'h007);
        send(0, 6, -1, 2'd0, 1'b0);
    endtask
    task automatic test_hard_reset();
        set_req(3'd3, 2'd0, 5'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 9'h0);
        send(0, -1, -1, 2'd1, 1'b0);
    endtask
    task automatic test_abort();
        objs[0] = 32'hDEADBEEF;
        set_req(3'd0, 2'd1, 5'h04, 3'd2, 3'd1, 1'b1, 2'd1, 1'b1, 9'h0);
        send(0, -1, 3, 2'd0, 1'b0);
        set_req(3'd2, 2'd1, 5'h03, 3'd1, 3'd1, 1'b0, 2'd2, 1'b1, 9'h0);
        send(0, -1, -1, 2'd0, 1'b0);
    endtask
    task automatic test_reset_mid_data();
        objs[0] = 32'h01020304; objs[1] = 32'h05060708; objs[2] = 32'h090A0B0C;
        set_req(3'd0, 2'd1, 5'h01, 3'd1, 3'd3, 1'b0, 2'd2, 1'b0, 9'h0);
        @(negedge clk); prl_tx_message_req = 1'b1;
        @(posedge clk); #1 prl_tx_message_req = 1'b0;
        repeat (7) begin
            @(negedge clk); phy2prl_tx_payload_req = 1'b1;
            @(posedge clk); #1 phy2prl_tx_payload_req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (prl_tx_data_obj_idx !== 3'd1) begin errors++; $display("FAIL pre_reset_idx: got %0d want 1", prl_tx_data_obj_idx); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_data");
        phy2prl_tx_packet_done = 1'b1; phy2prl_tx_packet_result = 2'd2;
        @(posedge clk); #1 phy2prl_tx_packet_done = 1'b0;
        @(negedge clk);
        check_all_zero("no_done_after_reset");
    endtask
    task automatic test_random();
        int n_est;
        for (int t = 0; t < 25; t++) begin
            for (int o = 0; o < 8; o++) objs[o] = $urandom;
            set_req(($urandom_range(0, 5) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2)),
                    2'($urandom_range(0, 3)), 5'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                    2'($urandom), 1'($urandom), 9'($urandom));
            n_est = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : -1;
            send(2, -1, n_est, 2'($urandom), 1'($urandom));
        end
    endtask
    initial begin
        rst = 1'b1;
        prl_tx_message_req = 1'b0;
        phy2prl_tx_payload_req = 1'b0;
        phy2prl_tx_packet_done = 1'b0;
        phy2prl_tx_packet_result = 2'd0;
        for (int o = 0; o < 8; o++) objs[o] = 32'h0;
        set_req(3'd0, 2'd0, 5'h0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 9'h0);
        test_reset();
        test_goodcrc();
        test_data_msg();
        test_extended();
        test_hard_reset();
        test_abort();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
